// File: rtl/hazard_unit_mc_if.sv
// Pipeline-field inputs and datapath control outputs of the hazard unit.
// The datapath side is the master; the hazard unit is the slave.
interface hazard_unit_mc_if #(
  parameter int RA_W = 5
);
  logic [RA_W-1:0] d_rs;
  logic [RA_W-1:0] d_rt;
  logic [RA_W-1:0] e_rs;
  logic [RA_W-1:0] e_rt;
  logic [RA_W-1:0] e_rf_wa;
  logic [RA_W-1:0] m_rf_wa;
  logic [RA_W-1:0] w_rf_wa;
  logic            e_rf_we;
  logic            m_rf_we;
  logic            w_rf_we;
  logic            e_is_load;
  logic            m_is_load;
  logic            d_is_branch;
  logic            d_pc_src;
  logic            d_uses_mdu;
  logic            mdu_start;
  logic [1:0]      sel_forward_alu_a;
  logic [1:0]      sel_forward_alu_b;
  logic            sel_forward_br_a;
  logic            sel_forward_br_b;
  logic            f_stall;
  logic            d_stall;
  logic            d_flush;
  logic            e_flush;
  logic            mdu_busy;

  modport master (
    output d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa,
           e_rf_we, m_rf_we, w_rf_we, e_is_load, m_is_load,
           d_is_branch, d_pc_src, d_uses_mdu, mdu_start,
    input  sel_forward_alu_a, sel_forward_alu_b, sel_forward_br_a, sel_forward_br_b,
           f_stall, d_stall, d_flush, e_flush, mdu_busy
  );

  modport slave (
    input  d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa,
           e_rf_we, m_rf_we, w_rf_we, e_is_load, m_is_load,
           d_is_branch, d_pc_src, d_uses_mdu, mdu_start,
    output sel_forward_alu_a, sel_forward_alu_b, sel_forward_br_a, sel_forward_br_b,
           f_stall, d_stall, d_flush, e_flush, mdu_busy
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage pipeline: forwarding selects, load-use / branch / MDU
// stalls with multi-cycle load and MDU counters, and taken-branch flush.
module hazard_unit_mc #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_mc_if.slave hz
);
  localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int MD_W = $clog2(MDU_LAT + 1);

  logic [LD_W-1:0] r_ld_cnt;
  logic [MD_W-1:0] r_mdu_cnt;

  logic       w_lu, w_br_e, w_br_m, w_md;
  logic       w_stall_pre, w_stall, w_mdu_busy;
  logic [1:0] w_sel_a, w_sel_b;
  logic       w_br_a, w_br_b;

  function automatic logic f_match(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign w_sel_a = (f_match(hz.e_rs, hz.m_rf_wa) && hz.m_rf_we) ? 2'b10 :
                   (f_match(hz.e_rs, hz.w_rf_wa) && hz.w_rf_we) ? 2'b01 : 2'b00;
  assign w_sel_b = (f_match(hz.e_rt, hz.m_rf_wa) && hz.m_rf_we) ? 2'b10 :
                   (f_match(hz.e_rt, hz.w_rf_wa) && hz.w_rf_we) ? 2'b01 : 2'b00;
  assign w_br_a  = f_match(hz.d_rs, hz.m_rf_wa) && hz.m_rf_we && !hz.m_is_load;
  assign w_br_b  = f_match(hz.d_rt, hz.m_rf_wa) && hz.m_rf_we && !hz.m_is_load;

  assign w_lu   = hz.e_is_load && hz.e_rf_we &&
                  (f_match(hz.d_rs, hz.e_rf_wa) || f_match(hz.d_rt, hz.e_rf_wa));
  assign w_br_e = hz.d_is_branch && hz.e_rf_we &&
                  (f_match(hz.d_rs, hz.e_rf_wa) || f_match(hz.d_rt, hz.e_rf_wa));
  assign w_br_m = hz.d_is_branch && hz.m_is_load && hz.m_rf_we &&
                  (f_match(hz.d_rs, hz.m_rf_wa) || f_match(hz.d_rt, hz.m_rf_wa));
  assign w_mdu_busy = (r_mdu_cnt != '0);
  assign w_md       = hz.d_uses_mdu && (w_mdu_busy || hz.mdu_start);

  // A stall caused only by the MDU itself must not cancel the op that raised it.
  assign w_stall_pre = w_lu || w_br_e || w_br_m || (r_ld_cnt != '0);
  assign w_stall     = w_stall_pre || w_md;

  always_comb begin
    hz.sel_forward_alu_a = 2'b00;
    hz.sel_forward_alu_b = 2'b00;
    hz.sel_forward_br_a  = 1'b0;
    hz.sel_forward_br_b  = 1'b0;
    hz.f_stall           = 1'b0;
    hz.d_stall           = 1'b0;
    hz.e_flush           = 1'b0;
    hz.d_flush           = 1'b0;
    hz.mdu_busy          = 1'b0;
    if (reset) begin
      hz.sel_forward_alu_a = w_sel_a;
      hz.sel_forward_alu_b = w_sel_b;
      hz.sel_forward_br_a  = w_br_a;
      hz.sel_forward_br_b  = w_br_b;
      hz.f_stall           = w_stall;
      hz.d_stall           = w_stall;
      hz.e_flush           = w_stall;
      hz.d_flush           = hz.d_pc_src && !w_stall;
      hz.mdu_busy          = w_mdu_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ld_cnt  <= '0;
      r_mdu_cnt <= '0;
    end else begin
      // The first bubble is the load-use cycle itself; the counter adds the rest.
      if (w_lu && (r_ld_cnt == '0)) begin
        r_ld_cnt <= LD_W'(LOAD_LAT - 1);
      end else if (r_ld_cnt != '0) begin
        r_ld_cnt <= r_ld_cnt - LD_W'(1);
      end

      if (hz.mdu_start && !w_stall_pre) begin
        r_mdu_cnt <= MD_W'(MDU_LAT);
      end else if (r_mdu_cnt != '0) begin
        r_mdu_cnt <= r_mdu_cnt - MD_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench: one unit with single-cycle loads, one with LOAD_LAT=3,
// combinational vector table plus multi-cycle sequences.
module tb_hazard_unit_mc;
  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
  logic       e_we, m_we, w_we, e_ld, m_ld, d_br, pc_src, d_mdu, mdu_st;

  hazard_unit_mc_if #(.RA_W(5)) if1 ();
  hazard_unit_mc_if #(.RA_W(5)) if3 ();

  assign if1.d_rs = d_rs;        assign if3.d_rs = d_rs;
  assign if1.d_rt = d_rt;        assign if3.d_rt = d_rt;
  assign if1.e_rs = e_rs;        assign if3.e_rs = e_rs;
  assign if1.e_rt = e_rt;        assign if3.e_rt = e_rt;
  assign if1.e_rf_wa = e_wa;     assign if3.e_rf_wa = e_wa;
  assign if1.m_rf_wa = m_wa;     assign if3.m_rf_wa = m_wa;
  assign if1.w_rf_wa = w_wa;     assign if3.w_rf_wa = w_wa;
  assign if1.e_rf_we = e_we;     assign if3.e_rf_we = e_we;
  assign if1.m_rf_we = m_we;     assign if3.m_rf_we = m_we;
  assign if1.w_rf_we = w_we;     assign if3.w_rf_we = w_we;
  assign if1.e_is_load = e_ld;   assign if3.e_is_load = e_ld;
  assign if1.m_is_load = m_ld;   assign if3.m_is_load = m_ld;
  assign if1.d_is_branch = d_br; assign if3.d_is_branch = d_br;
  assign if1.d_pc_src = pc_src;  assign if3.d_pc_src = pc_src;
  assign if1.d_uses_mdu = d_mdu; assign if3.d_uses_mdu = d_mdu;
  assign if1.mdu_start = mdu_st; assign if3.mdu_start = mdu_st;

  hazard_unit_mc #(.RA_W(5), .LOAD_LAT(1), .MDU_LAT(4)) dut1 (.clk(clk), .reset(rst1), .hz(if1));
  hazard_unit_mc #(.RA_W(5), .LOAD_LAT(3), .MDU_LAT(4)) dut3 (.clk(clk), .reset(rst3), .hz(if3));

  // Packed view: {0, alu_a, alu_b, br_a, br_b, f_stall, d_stall, e_flush, d_flush, mdu_busy}
  logic [11:0] out1, out3;
  assign out1 = {1'b0, if1.sel_forward_alu_a, if1.sel_forward_alu_b, if1.sel_forward_br_a,
                 if1.sel_forward_br_b, if1.f_stall, if1.d_stall, if1.e_flush, if1.d_flush,
                 if1.mdu_busy};
  assign out3 = {1'b0, if3.sel_forward_alu_a, if3.sel_forward_alu_b, if3.sel_forward_br_a,
                 if3.sel_forward_br_b, if3.f_stall, if3.d_stall, if3.e_flush, if3.d_flush,
                 if3.mdu_busy};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [11:0] ex(input logic [1:0] a, input logic [1:0] b, input logic bra,
                                     input logic brb, input logic st, input logic df,
                                     input logic busy);
    return {1'b0, a, b, bra, brb, st, st, st, df, busy};
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end else begin
      $display("ok   %s %b", nm, act);
    end
  endtask

  task automatic idle_in();
    d_rs = 0; d_rt = 0; e_rs = 0; e_rt = 0; e_wa = 0; m_wa = 0; w_wa = 0;
    e_we = 0; m_we = 0; w_we = 0; e_ld = 0; m_ld = 0; d_br = 0; pc_src = 0;
    d_mdu = 0; mdu_st = 0;
  endtask

  // Move to just after the next rising edge; caller drives, waits #2, then checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
    logic       e_we, m_we, w_we, e_ld, m_ld, d_br, pc_src, d_mdu;
    logic [1:0] x_a, x_b;
    logic       x_bra, x_brb, x_stall, x_df;
  } vec_t;

  vec_t vecs[16];

  initial begin
    //        name          drs drt ers ert ewa mwa wwa ewe mwe wwe eld mld dbr pcs dmd  a      b     bra brb st df
    vecs[0]  = '{"idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[1]  = '{"fwd_a_m",    0, 0, 3, 0, 0, 3, 3, 0, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[2]  = '{"fwd_a_w",    0, 0, 3, 0, 0, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0};
    vecs[3]  = '{"fwd_a_r0",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[4]  = '{"fwd_b_m",    0, 0, 4, 9, 0, 9, 9, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0};
    vecs[5]  = '{"fwd_ab_mw",  0, 0, 8, 9, 0, 8, 9, 0, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0};
    vecs[6]  = '{"fwd_we0",    0, 0, 3, 3, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[7]  = '{"br_fwd_m",   6, 6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    vecs[8]  = '{"br_fwd_ld",  6, 6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[9]  = '{"br_m_load",  0, 6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0};
    vecs[10] = '{"lu_rs",      5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0};
    vecs[11] = '{"lu_no_we",   5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[12] = '{"lu_r0",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[13] = '{"br_e",       0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0};
    vecs[14] = '{"taken",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1};
    vecs[15] = '{"mdu_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0};

    // Reset: outputs forced low even with an active forwarding pattern.
    idle_in();
    rst1 = 1'b0; rst3 = 1'b0;
    e_rs = 3; m_wa = 3; m_we = 1; d_rs = 3; pc_src = 1;
    #2;
    chk("reset_out1", out1, 12'd0);
    chk("reset_out3", out3, 12'd0);
    tick(); tick();
    idle_in();
    rst1 = 1'b1;
    #2;
    chk("post_reset1", out1, 12'd0);

    // Combinational table against the single-cycle-load unit (dut3 held in reset).
    for (int i = 0; i < 16; i++) begin
      tick();
      d_rs = vecs[i].d_rs; d_rt = vecs[i].d_rt; e_rs = vecs[i].e_rs; e_rt = vecs[i].e_rt;
      e_wa = vecs[i].e_wa; m_wa = vecs[i].m_wa; w_wa = vecs[i].w_wa;
      e_we = vecs[i].e_we; m_we = vecs[i].m_we; w_we = vecs[i].w_we;
      e_ld = vecs[i].e_ld; m_ld = vecs[i].m_ld; d_br = vecs[i].d_br;
      pc_src = vecs[i].pc_src; d_mdu = vecs[i].d_mdu; mdu_st = 1'b0;
      #2;
      chk(vecs[i].name, out1, ex(vecs[i].x_a, vecs[i].x_b, vecs[i].x_bra, vecs[i].x_brb,
                                 vecs[i].x_stall, vecs[i].x_df, 1'b0));
    end

    // Load-use: LOAD_LAT=1 stalls once, LOAD_LAT=3 stalls three cycles.
    tick(); idle_in(); rst3 = 1'b1;
    tick();
    d_rs = 5; e_ld = 1; e_we = 1; e_wa = 5;
    #2;
    chk("lu1_c0", out1, ex(0, 0, 0, 0, 1, 0, 0));
    chk("lu3_c0", out3, ex(0, 0, 0, 0, 1, 0, 0));
    tick(); e_ld = 0; e_we = 0; e_wa = 0;
    #2;
    chk("lu1_c1", out1, ex(0, 0, 0, 0, 0, 0, 0));
    chk("lu3_c1", out3, ex(0, 0, 0, 0, 1, 0, 0));
    tick(); #2;
    chk("lu3_c2", out3, ex(0, 0, 0, 0, 1, 0, 0));
    tick(); #2;
    chk("lu3_c3", out3, ex(0, 0, 0, 0, 0, 0, 0));

    // Branch operand in E, then forwarded from M once it advances.
    tick(); idle_in();
    d_br = 1; d_rt = 7; e_wa = 7; e_we = 1; pc_src = 1;
    #2;
    chk("br_c0", out1, ex(0, 0, 0, 0, 1, 0, 0));
    tick(); e_we = 0; e_wa = 0; m_wa = 7; m_we = 1; m_ld = 0;
    #2;
    chk("br_c1", out1, ex(0, 0, 0, 1, 0, 1, 0));

    // MDU pulse with a dependent D instruction held.
    tick(); idle_in();
    d_mdu = 1; mdu_st = 1;
    #2;
    chk("mdu_c0", out1, ex(0, 0, 0, 0, 1, 0, 0));
    for (int c = 1; c <= 4; c++) begin
      tick(); mdu_st = 0;
      #2;
      chk($sformatf("mdu_c%0d", c), out1, ex(0, 0, 0, 0, 1, 0, 1));
    end
    tick(); #2;
    chk("mdu_c5", out1, ex(0, 0, 0, 0, 0, 0, 0));

    // Restart while busy: counter reloads to full latency.
    tick(); idle_in(); mdu_st = 1;
    tick(); mdu_st = 0;
    tick();
    tick(); mdu_st = 1;
    #2;
    chk("mdu_rs_c3", out1, ex(0, 0, 0, 0, 0, 0, 1));
    tick(); mdu_st = 0;
    tick(); tick(); tick();
    #2;
    chk("mdu_rs_c7", out1, ex(0, 0, 0, 0, 0, 0, 1));
    tick(); #2;
    chk("mdu_rs_c8", out1, ex(0, 0, 0, 0, 0, 0, 0));

    // mdu_start swallowed when a load-use stall flushes E.
    tick(); idle_in();
    mdu_st = 1; d_rs = 5; e_ld = 1; e_we = 1; e_wa = 5;
    #2;
    chk("mdu_blk_c0", out1, ex(0, 0, 0, 0, 1, 0, 0));
    tick(); idle_in();
    #2;
    chk("mdu_blk_c1", out1, ex(0, 0, 0, 0, 0, 0, 0));
    tick(); tick(); tick();

    // Reset mid load-use stall on the LOAD_LAT=3 unit.
    tick(); idle_in();
    d_rs = 5; e_ld = 1; e_we = 1; e_wa = 5;
    tick(); e_ld = 0; e_we = 0; e_wa = 0;
    e_rs = 3; m_wa = 3; m_we = 1;
    #2;
    chk("rst_mid_pre", out3, ex(2'b10, 0, 0, 0, 1, 0, 0));
    rst3 = 1'b0;
    #1;
    chk("rst_mid_now", out3, 12'd0);
    tick(); rst3 = 1'b1; idle_in();
    #2;
    chk("rst_mid_after", out3, ex(0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
